// File: rtl/sap_cpu_gen2_if.sv
// sap_cpu_gen2_if: control, program-load and status bundle for sap_cpu_gen2.
//   en         step enable (driven by master)
//   prog       program mode: RAM write port active, core idle
//   prog_addr  RAM write address while prog=1
//   prog_data  RAM write data while prog=1
//   out_reg    output register (driven by core)
//   out_valid  one-cycle strobe on the edge that loads out_reg
//   halted     set by HLT
//   zero_flag  Z flag
//   carry_flag C flag (carry, or borrow on subtraction)
interface sap_cpu_gen2_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              en;
    logic              prog;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [DATA_W-1:0] out_reg;
    logic              out_valid;
    logic              halted;
    logic              zero_flag;
    logic              carry_flag;

    modport master (
        output en, prog, prog_addr, prog_data,
        input  out_reg, out_valid, halted, zero_flag, carry_flag
    );

    modport slave (
        input  en, prog, prog_addr, prog_data,
        output out_reg, out_valid, halted, zero_flag, carry_flag
    );
endinterface

// File: rtl/sap_cpu_gen2.sv
// sap_cpu_gen2: multi-cycle accumulator CPU with variable-length microcode.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    sap_cpu_gen2_if.slave (en, prog load port, out_reg/out_valid, status flags)
//
// step | meaning
// -----+-------------------------------------------------------
// T0   | mar <= pc
// T1   | ir <= ram[mar], pc <= pc + 1
// T2   | execute: three-cycle ops finish here, memory ops set mar
// T3   | execute: memory read/write and ALU result for four-cycle ops
module sap_cpu_gen2 #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input logic           clk,
    input logic           reset,
    sap_cpu_gen2_if.slave bus
);
    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_OUT = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_STA = 4'h5;
    localparam logic [3:0] OP_LDI = 4'h6;
    localparam logic [3:0] OP_SUB = 4'h7;
    localparam logic [3:0] OP_BEQ = 4'h8;
    localparam logic [3:0] OP_CMP = 4'h9;
    localparam logic [3:0] OP_JMC = 4'hA;
    localparam logic [3:0] OP_BNE = 4'hB;
    localparam logic [3:0] OP_AND = 4'hC;
    localparam logic [3:0] OP_OR  = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

    logic [1:0]        step;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] out_reg;
    logic              out_valid;
    logic              halted;
    logic              zf;
    logic              cf;

    logic [3:0]        op;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] mem;
    logic [DATA_W:0]   alu;
    logic              four_cycle;
    logic              sta_wr;

    assign op      = ir[DATA_W-1 -: 4];
    assign operand = ir[ADDR_W-1:0];
    assign mem     = ram[mar];

    // Bit DATA_W carries the carry-out for ADD and the unsigned borrow for SUB/CMP.
    always_comb begin
        alu = {1'b0, a} + {1'b0, mem};
        case (op)
            OP_SUB, OP_CMP: alu = {1'b0, a} - {1'b0, mem};
            OP_AND:         alu = {1'b0, a & mem};
            OP_OR:          alu = {1'b0, a | mem};
            default:        alu = {1'b0, a} + {1'b0, mem};
        endcase
    end

    always_comb begin
        four_cycle = 1'b0;
        case (op)
            OP_LDA, OP_ADD, OP_STA, OP_SUB,
            OP_CMP, OP_AND, OP_OR:  four_cycle = 1'b1;
            default:                four_cycle = 1'b0;
        endcase
    end

    assign sta_wr = reset && !bus.prog && bus.en && !halted
                    && (step == T3) && (op == OP_STA);

    // RAM has no reset; the load port wins over a store from the core.
    always_ff @(posedge clk) begin
        if (bus.prog)
            ram[bus.prog_addr] <= bus.prog_data;
        else if (sta_wr)
            ram[mar] <= a;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step      <= T0;
            pc        <= '0;
            mar       <= '0;
            ir        <= '0;
            a         <= '0;
            out_reg   <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
            zf        <= 1'b0;
            cf        <= 1'b0;
        end else if (bus.prog) begin
            // out_reg deliberately survives a reload so the last result stays visible.
            step      <= T0;
            pc        <= '0;
            mar       <= '0;
            ir        <= '0;
            a         <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
            zf        <= 1'b0;
            cf        <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (bus.en && !halted) begin
                case (step)
                    T0: begin
                        mar  <= pc;
                        step <= T1;
                    end
                    T1: begin
                        ir   <= mem;
                        pc   <= pc + ADDR_W'(1);
                        step <= T2;
                    end
                    T2: begin
                        step <= four_cycle ? T3 : T0;
                        case (op)
                            OP_LDA, OP_ADD, OP_STA, OP_SUB,
                            OP_CMP, OP_AND, OP_OR: mar <= operand;
                            OP_OUT: begin
                                out_reg   <= a;
                                out_valid <= 1'b1;
                            end
                            OP_JMP: pc <= operand;
                            OP_LDI: a  <= DATA_W'(operand);
                            OP_BEQ: if (zf)  pc <= operand;
                            OP_JMC: if (cf)  pc <= operand;
                            OP_BNE: if (!zf) pc <= operand;
                            OP_HLT: halted <= 1'b1;
                            default: ;
                        endcase
                    end
                    default: begin
                        step <= T0;
                        case (op)
                            OP_LDA: a <= mem;
                            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                                a  <= alu[DATA_W-1:0];
                                cf <= alu[DATA_W];
                                zf <= (alu[DATA_W-1:0] == '0);
                            end
                            OP_CMP: begin
                                cf <= alu[DATA_W];
                                zf <= (alu[DATA_W-1:0] == '0);
                            end
                            default: ;
                        endcase
                    end
                endcase
            end
        end
    end

    assign bus.out_reg    = out_reg;
    assign bus.out_valid  = out_valid;
    assign bus.halted     = halted;
    assign bus.zero_flag  = zf;
    assign bus.carry_flag = cf;
endmodule
